// File: rtl/priority_arbiter_pkg.sv
// priority_arbiter_pkg
// Shared types and constants for the five-requester fixed-priority arbiter.
//   ARB_N     : number of requesters (fixed at 5)
//   arb_vec_t : one bit per requester, bit 0 = highest priority
//   ARB_NONE  : all-zero vector (no request / no grant)
package priority_arbiter_pkg;

  localparam int unsigned ARB_N = 5;

  typedef logic [ARB_N-1:0] arb_vec_t;

  localparam arb_vec_t ARB_NONE = {ARB_N{1'b0}};

endpackage : priority_arbiter_pkg

// File: rtl/priority_encoder_onehot.sv
// priority_encoder_onehot
// Combinational request-vector to one-hot grant encoder. The lowest-index
// asserted request wins; an all-zero request vector yields an all-zero grant.
// Ports:
//   req_i : request vector, bit 0 = highest priority
//   gnt_o : one-hot (or all-zero) grant vector
module priority_encoder_onehot
  import priority_arbiter_pkg::*;
(
  input  arb_vec_t req_i,
  output arb_vec_t gnt_o
);

  arb_vec_t req_neg_s;

  // Two's-complement negation: req & -req isolates the lowest set bit,
  // which is exactly the highest-priority active request.
  always_comb begin
    req_neg_s = ~req_i + arb_vec_t'(1'b1);
    gnt_o     = req_i & req_neg_s;
  end

endmodule : priority_encoder_onehot

// File: rtl/priority_arbiter.sv
// priority_arbiter
// Five-requester fixed-priority arbiter with registered one-hot grants.
// req0 has the highest priority, req4 the lowest. Grants appear one clock
// after the request pattern is sampled and are always one-hot or all-zero.
// Optional build macro:
//   PRIORITY_ARBITER_LOCK_EN : when defined, the current grantee keeps its
//                              grant while its own request stays high
//                              (non-preemptive). Undefined: fully preemptive.
// Ports:
//   clock       : system clock, rising-edge active
//   reset       : asynchronous active-high reset, clears all grants
//   req0..req4  : requests, req0 highest priority
//   gnt0..gnt4  : registered grants, at most one high
module priority_arbiter
  import priority_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic req4,
  output logic gnt0,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic gnt4
);

  arb_vec_t req_vec_s;
  arb_vec_t pri_gnt_s;
  arb_vec_t gnt_d;
  arb_vec_t gnt_q;

  // Pack the discrete request pins so bit index equals priority level.
  always_comb begin
    req_vec_s = {req4, req3, req2, req1, req0};
  end

  priority_encoder_onehot u_encoder (
    .req_i (req_vec_s),
    .gnt_o (pri_gnt_s)
  );

`ifdef PRIORITY_ARBITER_LOCK_EN
  // Next grant: hold the current grantee while its own request stays high,
  // otherwise fall back to the plain priority decision.
  always_comb begin
    if ((gnt_q & req_vec_s) != ARB_NONE) begin
      gnt_d = gnt_q;
    end else begin
      gnt_d = pri_gnt_s;
    end
  end
`else
  // Next grant: purely preemptive, the priority decision every cycle.
  always_comb begin
    gnt_d = pri_gnt_s;
  end
`endif

  // Grant register; reset clears grants (and any lock) immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q <= ARB_NONE;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  assign gnt0 = gnt_q[0];
  assign gnt1 = gnt_q[1];
  assign gnt2 = gnt_q[2];
  assign gnt3 = gnt_q[3];
  assign gnt4 = gnt_q[4];

endmodule : priority_arbiter

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter
// Directed self-checking bench for priority_arbiter. Vectors are written as
// {req0,req1,req2,req3,req4} and grants observed as {gnt0,gnt1,gnt2,gnt3,gnt4}.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising
// edge, or mid-cycle for the asynchronous reset checks.
module tb_priority_arbiter;

  logic clock;
  logic reset;
  logic req0, req1, req2, req3, req4;
  logic gnt0, gnt1, gnt2, gnt3, gnt4;

  int vectors;
  int miscompares;

  priority_arbiter arbiter (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .req2  (req2),
    .req3  (req3),
    .req4  (req4),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .gnt2  (gnt2),
    .gnt3  (gnt3),
    .gnt4  (gnt4)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [4:0] gnt_vec();
    return {gnt0, gnt1, gnt2, gnt3, gnt4};
  endfunction

  // Expected grant for a {req0..req4} vector: leftmost set bit wins.
  function automatic logic [4:0] expect_gnt(input logic [4:0] r);
    if (r[4])      return 5'b10000;
    else if (r[3]) return 5'b01000;
    else if (r[2]) return 5'b00100;
    else if (r[1]) return 5'b00010;
    else if (r[0]) return 5'b00001;
    else           return 5'b00000;
  endfunction

  task automatic drive(input logic [4:0] r);
    {req0, req1, req2, req3, req4} = r;
  endtask

  // Change requests on the falling edge, return just after the rising edge.
  task automatic step(input logic [4:0] r);
    @(negedge clock);
    drive(r);
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = gnt_vec();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    vectors++;
    assert ($onehot0(obs)) else begin
      miscompares++;
      $error("FAIL %s_onehot: observed %b expected at most one bit set", tag, obs);
    end
  endtask

  initial begin
    logic [4:0] v;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    drive(5'b11111);

    // Reset with all requests active: grants clear without any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 5'b00000);
    @(posedge clock);
    #1;
    check("reset_held", 5'b00000);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("first_grant", 5'b10000);

    // Hand-picked patterns.
    step(5'b00110); check("hand_00110", 5'b00100);
    step(5'b00001); check("hand_00001", 5'b00001);
    step(5'b00000); check("hand_00000", 5'b00000);
    step(5'b01011); check("hand_01011", 5'b01000);

    // Sweep of every pattern; an idle cycle between keeps any lock released.
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      step(5'b00000);
      step(v);
      check($sformatf("sweep_%b", v), expect_gnt(v));
    end

    // Higher-priority request arriving while req3 holds the grant.
    step(5'b00000);
    step(5'b00010); check("req3_alone", 5'b00010);
`ifdef PRIORITY_ARBITER_LOCK_EN
    step(5'b01010); check("lock_hold", 5'b00010);
    step(5'b01010); check("lock_hold2", 5'b00010);
    step(5'b01000); check("lock_release", 5'b01000);
`else
    step(5'b01010); check("preempt", 5'b01000);
    step(5'b00010); check("preempt_return", 5'b00010);
`endif

    // Reset pulse between edges while gnt2 is granted.
    step(5'b00100); check("mid_gnt2", 5'b00100);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_async", 5'b00000);
    #1;
    reset = 1'b0;
    #1;
    check("mid_reset_released", 5'b00000);
    @(posedge clock);
    #1;
    check("mid_resume", 5'b00100);

    // Idle: all requests low for five cycles.
    for (int i = 0; i < 5; i++) begin
      step(5'b00000);
      check($sformatf("idle_%0d", i), 5'b00000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_priority_arbiter
